l1i_refill_ctrl: RTL and testbench
==================================

// Module: l1i_refill_ctrl
// PURPOSE
//  Miss/refill controller between the L1 instruction cache and the backing L2/memory port.
//  Accepts a blocking fetch-miss request (level valid + 32-bit pc) from the L1I.
//  Either replays it from a one-word last-fetch buffer, or issues a req/gnt request to memory
//    and waits for the rvalid response.
//  Returns the word to the L1I refill port as a one-cycle valid pulse with data.
//  Detects lost memory responses with a timeout and retries them.
// PARAMETERS
//  ADDR_W     32   address width (L1I pc width)
//  DATA_W     32   instruction word width
//  TIMEOUT    64   cycles in WAIT without rvalid before retry; legal range 2..255
//  MAX_RETRY  3    retries before raising err_o and dropping the request
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  l1_req_i     in   1       L1I miss request, level; held until l1_valid_o
//  l1_addr_i    in   ADDR_W  miss address; stable while l1_req_i is high
//  l1_valid_o   out  1       refill data valid, one-cycle pulse
//  l1_dat_o     out  DATA_W  refill word; qualified by l1_valid_o
//  mem_req_o    out  1       memory request, held until mem_gnt_i
//  mem_addr_o   out  ADDR_W  memory address; word aligned ([1:0] forced to 0)
//  mem_gnt_i    in   1       memory accepts the request this cycle
//  mem_rvalid_i in   1       memory response valid
//  mem_rdata_i  in   DATA_W  memory response data
//  err_o        out  1       sticky: retries exhausted; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; buf_vld=0; retry_cnt=0; tmo_cnt=0.
//   - l1_valid_o, mem_req_o, err_o = 0; l1_dat_o, mem_addr_o = 0.
//  Registers: req_addr, buf_addr, buf_dat, buf_vld, tmo_cnt (8b), retry_cnt (2b).
//  FSM states: IDLE, REQ, WAIT, RESP, COOL.
//  IDLE
//   - l1_req_i=1 and buf_vld=1 and l1_addr_i[31:2]==buf_addr[31:2]:
//     -> RESP with buf_dat (buffer hit; l1_valid_o 1 cycle after request).
//   - l1_req_i=1 otherwise: capture req_addr, -> REQ.
//  REQ
//   - mem_req_o=1, mem_addr_o={req_addr[31:2],2'b00}.
//   - mem_gnt_i=1: -> WAIT, tmo_cnt=0.
//   - mem_gnt_i=1 and mem_rvalid_i=1 in the same cycle: latch data, -> RESP (zero-wait memory).
//  WAIT
//   - mem_req_o=0; tmo_cnt increments each cycle.
//   - mem_rvalid_i=1: buf_dat=mem_rdata_i, buf_addr=req_addr, buf_vld=1, retry_cnt=0, -> RESP.
//   - tmo_cnt==TIMEOUT-1 without rvalid:
//     - retry_cnt<MAX_RETRY: retry_cnt++, -> REQ.
//     - otherwise: err_o=1, retry_cnt=0, -> COOL (no l1_valid_o).
//  RESP
//   - l1_valid_o=1, l1_dat_o=buf_dat for exactly one cycle; -> COOL.
//  COOL
//   - One dead cycle; l1_req_i ignored while the L1I tag write settles; -> IDLE.
//  Latency: buffer hit = 1 cycle to l1_valid_o; miss = 1 + gnt wait + rvalid wait + 1.
//  Boundaries and ordering:
//   - Rvalid outside WAIT/REQ (stale response after a retry) is ignored; buffer is not updated.
//   - l1_req_i dropping in REQ/WAIT: the transaction completes; l1_valid_o still pulses;
//     the L1I discards it.
//   - l1_addr_i changing mid-transaction has no effect; req_addr is used.
//   - A new request at COOL is accepted only in the following IDLE cycle.
//   - Async reset mid-transaction:
//     - all state is cleared immediately; buf_vld=0; outputs go low in the same cycle;
//     - a later memory rvalid is ignored.
//  Only tmo_cnt wraps, and it is cleared on every entry to WAIT.
// STRUCTURE
//  Shared package l1i_pkg:
//   - state enum {IDLE,REQ,WAIT,RESP,COOL};
//   - ADDR_W, DATA_W, word-offset constant (2).
//  Natural sub-module: l1i_fetch_buf. It holds buf_addr/buf_dat/buf_vld and provides
//    a hit compare plus write/clear ports. The FSM and counters stay in the top.
// TESTING
//  1. Reset, then l1_req_i=1, addr=0x0000_0104; gnt after 2 cycles; rvalid with 0xDEAD_BEEF
//     3 cycles later -> mem_addr_o=0x104; single l1_valid_o pulse carrying 0xDEAD_BEEF.
//  2. Repeat request to 0x106 after scenario 1 -> buffer hit: l1_valid_o 1 cycle after
//     request, no mem_req_o.
//  3. Same cycle gnt+rvalid with 0x1234_5678 -> l1_valid_o next cycle, data 0x1234_5678,
//     WAIT skipped.
//  4. TIMEOUT=4, no rvalid -> 3 re-issued mem_req_o; after the 4th timeout err_o=1,
//     no l1_valid_o, FSM back to IDLE.
//  5. Reset asserted while in WAIT, then rvalid -> all outputs 0; buf_vld=0;
//     next request to the same addr misses.
//  6. l1_req_i held high across RESP -> COOL blocks it; request re-accepted as a buffer hit
//     2 cycles after the pulse.

Source files
------------

// File: rtl/l1i_pkg.sv
// Shared types and constants for the L1I miss/refill controller.
package l1i_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  // Number of byte-offset bits below a fetch word
  localparam int WORD_OFF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_COOL = 3'd4
  } l1i_state_e;

endpackage

// File: rtl/l1i_fetch_buf.sv
// One-word last-fetch buffer: remembers the most recent memory refill so that a
// repeated miss to the same word can be served without touching memory.
module l1i_fetch_buf #(
  parameter int ADDR_W = l1i_pkg::ADDR_W,
  parameter int DATA_W = l1i_pkg::DATA_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_wr,
  input  logic [ADDR_W-1:l1i_pkg::WORD_OFF]   i_wr_addr,
  input  logic [DATA_W-1:0]                   i_wr_dat,
  input  logic                                i_clr,
  input  logic [ADDR_W-1:l1i_pkg::WORD_OFF]   i_lk_addr,
  output logic                                o_hit,
  output logic [DATA_W-1:0]                   o_dat
);

  import l1i_pkg::*;

  logic [ADDR_W-1:WORD_OFF] r_buf_addr;
  logic [DATA_W-1:0]        r_buf_dat;
  logic                     r_buf_vld;

  // Buffer storage: clear wins over write, otherwise hold the last refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_addr <= {(ADDR_W-WORD_OFF){1'b0}};
      r_buf_dat  <= {DATA_W{1'b0}};
      r_buf_vld  <= 1'b0;
    end else if (i_clr) begin
      r_buf_vld  <= 1'b0;
    end else if (i_wr) begin
      r_buf_addr <= i_wr_addr;
      r_buf_dat  <= i_wr_dat;
      r_buf_vld  <= 1'b1;
    end else begin
      r_buf_vld  <= r_buf_vld;
    end
  end

  // Word-granular hit compare against the lookup address
  always_comb begin
    o_hit = 1'b0;
    if (r_buf_vld && (i_lk_addr == r_buf_addr)) begin
      o_hit = 1'b1;
    end else begin
      o_hit = 1'b0;
    end
  end

  assign o_dat = r_buf_dat;

endmodule

// File: rtl/l1i_refill_ctrl.sv
// L1I miss/refill controller: serves blocking fetch misses from a one-word
// buffer or from memory over a req/gnt + rvalid port, with timeout and retry.
module l1i_refill_ctrl #(
  parameter int ADDR_W    = l1i_pkg::ADDR_W,
  parameter int DATA_W    = l1i_pkg::DATA_W,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l1_req_i,
  input  logic [ADDR_W-1:0] l1_addr_i,
  output logic              l1_valid_o,
  output logic [DATA_W-1:0] l1_dat_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  import l1i_pkg::*;

  // Last WAIT cycle count before a timeout fires, and the retry ceiling
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

  l1i_state_e               r_state;
  l1i_state_e               w_state_nxt;
  logic [7:0]               r_tmo;
  logic [7:0]               w_tmo_nxt;
  logic [1:0]               r_retry;
  logic [1:0]               w_retry_nxt;
  logic [ADDR_W-1:WORD_OFF] r_req_addr;
  logic [ADDR_W-1:WORD_OFF] w_req_addr_nxt;

  logic                     w_buf_wr;
  logic                     w_buf_hit;
  logic [DATA_W-1:0]        w_buf_dat;
  logic                     w_err_set;
  logic [DATA_W-1:0]        w_dat_nxt;

  logic                     r_l1_valid;
  logic [DATA_W-1:0]        r_l1_dat;
  logic                     r_mem_req;
  logic                     r_err;

  // Byte offset within the fetch word plays no role in a word refill
  logic                     w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^l1_addr_i[WORD_OFF-1:0];

  l1i_fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (w_buf_wr),
    .i_wr_addr (r_req_addr),
    .i_wr_dat  (mem_rdata_i),
    .i_clr     (1'b0),
    .i_lk_addr (l1_addr_i[ADDR_W-1:WORD_OFF]),
    .o_hit     (w_buf_hit),
    .o_dat     (w_buf_dat)
  );

  // FSM state, timeout/retry counters and captured miss address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tmo      <= 8'd0;
      r_retry    <= 2'd0;
      r_req_addr <= {(ADDR_W-WORD_OFF){1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_tmo      <= w_tmo_nxt;
      r_retry    <= w_retry_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // Next-state logic; responses are only honoured while a request is in flight
  always_comb begin
    w_state_nxt    = r_state;
    w_tmo_nxt      = r_tmo;
    w_retry_nxt    = r_retry;
    w_req_addr_nxt = r_req_addr;
    w_buf_wr       = 1'b0;
    w_err_set      = 1'b0;
    w_dat_nxt      = {DATA_W{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (l1_req_i) begin
          if (w_buf_hit) begin
            w_dat_nxt   = w_buf_dat;
            w_state_nxt = ST_RESP;
          end else begin
            w_req_addr_nxt = l1_addr_i[ADDR_W-1:WORD_OFF];
            w_state_nxt    = ST_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          if (mem_rvalid_i) begin
            // Zero-wait memory: response arrives with the grant
            w_buf_wr    = 1'b1;
            w_retry_nxt = 2'd0;
            w_dat_nxt   = mem_rdata_i;
            w_state_nxt = ST_RESP;
          end else begin
            w_tmo_nxt   = 8'd0;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          w_buf_wr    = 1'b1;
          w_retry_nxt = 2'd0;
          w_dat_nxt   = mem_rdata_i;
          w_state_nxt = ST_RESP;
        end else if (r_tmo == TMO_LAST) begin
          if (r_retry < RETRY_LIM) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = ST_REQ;
          end else begin
            // Give up: flag the error and drop the request without a refill
            w_err_set   = 1'b1;
            w_retry_nxt = 2'd0;
            w_state_nxt = ST_COOL;
          end
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_COOL;
      end
      ST_COOL: begin
        // Dead cycle so the L1I tag write settles before the next miss
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs registered from the next state so they align with the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l1_valid <= 1'b0;
      r_l1_dat   <= {DATA_W{1'b0}};
      r_mem_req  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_l1_valid <= (w_state_nxt == ST_RESP);
      r_l1_dat   <= w_dat_nxt;
      r_mem_req  <= (w_state_nxt == ST_REQ);
      r_err      <= r_err | w_err_set;
    end
  end

  assign l1_valid_o = r_l1_valid;
  assign l1_dat_o   = r_l1_dat;
  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = {r_req_addr, {WORD_OFF{1'b0}}};
  assign err_o      = r_err;

endmodule

// File: tb/tb_l1i_refill_ctrl.sv
// Self-checking bench for l1i_refill_ctrl: directed memory behaviour with a
// refill-data scoreboard consumed on every l1_valid_o pulse.
module tb_l1i_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        l1_req_i;
  logic [31:0] l1_addr_i;
  logic        l1_valid_o;
  logic [31:0] l1_dat_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int          n_tests;
  int          n_fail;
  int          n_valid;
  int          n_req_cyc;
  logic [31:0] exp_q[$];

  l1i_refill_ctrl #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .TIMEOUT   (4),
    .MAX_RETRY (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .l1_req_i     (l1_req_i),
    .l1_addr_i    (l1_addr_i),
    .l1_valid_o   (l1_valid_o),
    .l1_dat_o     (l1_dat_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer and activity counters, sampled away from the active edge
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n === 1'b1) begin
      if (mem_req_o === 1'b1) n_req_cyc++;
      if (l1_valid_o === 1'b1) begin
        n_valid++;
        chk("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("l1_dat", 64'(l1_dat_o), 64'(e));
        end
      end
    end
  end

  initial begin
    int req_before;
    int grants;
    n_tests = 0; n_fail = 0; n_valid = 0; n_req_cyc = 0;
    rst_n = 1'b0; l1_req_i = 1'b0; l1_addr_i = 32'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    tick(); tick();
    chk("rst_l1_valid", 64'(l1_valid_o), 64'd0);
    chk("rst_l1_dat",   64'(l1_dat_o),   64'd0);
    chk("rst_mem_req",  64'(mem_req_o),  64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_err",      64'(err_o),      64'd0);
    rst_n = 1'b1;
    tick();

    // Scenario 1: miss, grant after 2 cycles, rvalid 3 cycles after grant
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0104;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    chk("s1_mem_req", 64'(mem_req_o), 64'd1);
    chk("s1_mem_addr", 64'(mem_addr_o), 64'h104);
    l1_addr_i = 32'h0000_FFF0;
    tick(); tick();
    chk("s1_req_held", 64'(mem_req_o), 64'd1);
    chk("s1_addr_stable", 64'(mem_addr_o), 64'h104);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("s1_req_drop", 64'(mem_req_o), 64'd0);
    tick(); tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    chk("s1_valid", 64'(l1_valid_o), 64'd1);
    l1_req_i = 1'b0;
    tick();
    chk("s1_single_pulse", 64'(l1_valid_o), 64'd0);
    tick();

    // Scenario 2: repeat to same word -> buffer hit, no memory traffic
    req_before = n_req_cyc;
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0106;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    chk("s2_hit_valid", 64'(l1_valid_o), 64'd1);
    chk("s2_no_mem_req", 64'(mem_req_o), 64'd0);
    l1_req_i = 1'b0;
    tick(); tick();
    chk("s2_no_req_cycles", 64'(n_req_cyc), 64'(req_before));

    // Scenario 3: grant and rvalid in the same cycle
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0200;
    exp_q.push_back(32'h1234_5678);
    tick();
    chk("s3_mem_req", 64'(mem_req_o), 64'd1);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    chk("s3_valid_next", 64'(l1_valid_o), 64'd1);
    l1_req_i = 1'b0;
    tick(); tick();

    // Scenario 4: memory never answers -> 1 issue + 3 retries, then err_o
    chk("s4_err_before", 64'(err_o), 64'd0);
    grants = 0;
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0300;
    for (int i = 0; i < 200 && err_o !== 1'b1; i++) begin
      mem_gnt_i = mem_req_o;
      tick();
      if (mem_gnt_i) grants++;
    end
    mem_gnt_i = 1'b0;
    l1_req_i = 1'b0;
    chk("s4_err", 64'(err_o), 64'd1);
    chk("s4_grants", 64'(grants), 64'd4);
    chk("s4_no_valid", 64'(l1_valid_o), 64'd0);
    tick(); tick();
    chk("s4_idle_no_req", 64'(mem_req_o), 64'd0);
    // Stale response while idle must be ignored
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0BAD;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    chk("s4_stale_ignored", 64'(l1_valid_o), 64'd0);
    chk("s4_err_sticky", 64'(err_o), 64'd1);
    tick();

    // Scenario 5: async reset while in WAIT, then a late rvalid
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0400;
    tick();
    chk("s5_mem_req", 64'(mem_req_o), 64'd1);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    l1_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 64'(l1_valid_o), 64'd0);
    chk("s5_rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("s5_rst_err", 64'(err_o), 64'd0);
    chk("s5_rst_mem_addr", 64'(mem_addr_o), 64'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    rst_n = 1'b1;
    tick();
    chk("s5_post_valid", 64'(l1_valid_o), 64'd0);
    // Word 0x200 was buffered before reset; it must now miss
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0200;
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    chk("s5_miss_req", 64'(mem_req_o), 64'd1);
    chk("s5_miss_no_valid", 64'(l1_valid_o), 64'd0);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
    chk("s5_refill_valid", 64'(l1_valid_o), 64'd1);
    l1_req_i = 1'b0;
    tick(); tick();

    // Scenario 6: request held through RESP is blocked by COOL, then hits
    l1_req_i = 1'b1; l1_addr_i = 32'h0000_0200;
    exp_q.push_back(32'hCAFE_F00D);
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    chk("s6_first_pulse", 64'(l1_valid_o), 64'd1);
    tick();
    chk("s6_cool_blocked", 64'(l1_valid_o), 64'd0);
    tick();
    chk("s6_idle_accept", 64'(l1_valid_o), 64'd0);
    tick();
    chk("s6_second_pulse", 64'(l1_valid_o), 64'd1);
    chk("s6_no_mem_req", 64'(mem_req_o), 64'd0);
    l1_req_i = 1'b0;
    tick(); tick(); tick();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("valid_count", 64'(n_valid), 64'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run can never hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
